// File: rtl/dp_arbiter.sv
// dp_arbiter: round-robin front end that shares one start/busy datapath between two requesters.
// Optional busy watchdog is compiled in with `define DP_ARB_TIMEOUT_EN.
module dp_arbiter #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       ack0,
  output logic       ack1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] result0,
  output logic [7:0] result1,
  output logic       err,
  output logic       dp_start,
  output logic [7:0] dp_ina,
  output logic [7:0] dp_inb,
  input  logic       dp_busy,
  input  logic [7:0] dp_out
);
  localparam int NUM_REQ = 2;

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, CAPTURE} state_t;
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
  } operand_t;

  state_t                      state, nxt;
  logic [NUM_REQ-1:0]          reqVec, ackVec, doneVec;
  operand_t [NUM_REQ-1:0]      opVec;
  logic [NUM_REQ-1:0][7:0]     resVec;
  logic                        grantIdx, winner, anyReq, finish, timedOut;
  logic [7:0]                  capData;

  assign reqVec   = {req1, req0};
  assign opVec[0] = '{a: a0, b: b0};
  assign opVec[1] = '{a: a1, b: b1};
  assign anyReq   = |reqVec;

  // grantIdx doubles as the round-robin pointer: the other requester wins a tie
  always_comb begin
    winner = 1'b0;
    if (&reqVec)        winner = ~grantIdx;
    else if (reqVec[1]) winner = 1'b1;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (anyReq) nxt = LAUNCH;
      LAUNCH:    nxt = WAIT_BUSY;
      WAIT_BUSY: if (timedOut) nxt = CAPTURE;
                 else if (dp_busy) nxt = RUN;
      RUN:       if (!dp_busy || timedOut) nxt = CAPTURE;
      CAPTURE:   nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  assign finish = (state inside {WAIT_BUSY, RUN}) && (nxt == CAPTURE);

`ifdef DP_ARB_TIMEOUT_EN
  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wdog;
  logic       wdogHit;

  always_ff @(posedge clk) begin
    if (reset)                                wdog <= '0;
    else if (state inside {WAIT_BUSY, RUN})   wdog <= wdog + 8'd1;
    else                                      wdog <= '0;
  end

  // a normal completion on the same edge as the limit is not a timeout
  assign wdogHit  = (state inside {WAIT_BUSY, RUN}) && (wdog == WDOG_LAST);
  assign timedOut = wdogHit && !(state == RUN && !dp_busy);

  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= finish && timedOut;
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = |TIMEOUT_CYCLES;
  assign timedOut      = 1'b0;
  assign err           = 1'b0;
`endif

  assign capData = timedOut ? 8'hFF : dp_out;

  // reset pointer at 1 so requester 0 wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grantIdx <= 1'b1;
      dp_start <= 1'b0;
      dp_ina   <= '0;
      dp_inb   <= '0;
    end else begin
      state    <= nxt;
      dp_start <= (state == IDLE) && anyReq;
      if (state == IDLE && anyReq) begin
        grantIdx <= winner;
        dp_ina   <= opVec[winner].a;
        dp_inb   <= opVec[winner].b;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : gLane
    logic       launchHit, captureHit, ackR, doneR;
    logic [7:0] resR;

    assign launchHit  = (state == IDLE) && anyReq && (winner == 1'(g));
    assign captureHit = finish && (grantIdx == 1'(g));

    always_ff @(posedge clk) begin
      if (reset) begin
        ackR  <= 1'b0;
        doneR <= 1'b0;
        resR  <= '0;
      end else begin
        ackR  <= launchHit;
        doneR <= captureHit;
        if (captureHit) resR <= capData;
      end
    end

    assign ackVec[g]  = ackR;
    assign doneVec[g] = doneR;
    assign resVec[g]  = resR;
  end

  assign ack0    = ackVec[0];
  assign ack1    = ackVec[1];
  assign done0   = doneVec[0];
  assign done1   = doneVec[1];
  assign result0 = resVec[0];
  assign result1 = resVec[1];

endmodule

// File: tb/tb_dp_arbiter.sv
// Bench for dp_arbiter: vector table, hand-written corner cases, and a randomized run
// against a transaction-level reference model. Datapath is a counting busy model.
module tb_dp_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic       ack0, ack1, done0, done1, err, dp_start;
  logic [7:0] result0, result1, dp_ina, dp_inb;
  logic       dp_busy = 1'b0;
  logic [7:0] dp_out = '0;

  int nApplied = 0;
  int nMis = 0;

  // datapath model controls
  int   dpLen = 3;
  logic dpStuck = 1'b0;
  int   busyCnt = 0;
  logic [7:0] opSum = '0;

  dp_arbiter #(.TIMEOUT_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
    .result0(result0), .result1(result1), .err(err),
    .dp_start(dp_start), .dp_ina(dp_ina), .dp_inb(dp_inb),
    .dp_busy(dp_busy), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  // busy for dpLen cycles after a start, output garbage until it finishes with a+b
  always @(negedge clk) begin
    if (dp_start) begin
      busyCnt = dpLen;
      opSum   = dp_ina + dp_inb;
      dp_busy = 1'b1;
      dp_out  = 8'($urandom);
    end else if (dp_busy && !dpStuck) begin
      busyCnt--;
      if (busyCnt <= 0) begin
        dp_busy = 1'b0;
        dp_out  = opSum;
      end else begin
        dp_out = 8'($urandom);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nApplied++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic r0; logic r1;
    logic [7:0] a0; logic [7:0] b0; logic [7:0] a1; logic [7:0] b1;
    int len; int expW; logic [7:0] expRes;
  } vec_t;
  vec_t tbl[8];

  int gq[$];
  int dq[$];
  logic [7:0] eRes[2];

  initial begin
    logic nd, early, seen, both, r0, r1;
    int w, doneAt, idleFrom, lastW, opW;
    logic [7:0] opRes, eInA, eInB;
    logic [1:0] eAck, eDone;
    logic eStart;

    tbl[0] = '{1'b1, 1'b0, 8'h05, 8'h03, 8'h11, 8'h22, 4, 0, 8'h08};
    tbl[1] = '{1'b1, 1'b1, 8'h10, 8'h20, 8'h30, 8'h40, 3, 1, 8'h70};
    tbl[2] = '{1'b1, 1'b1, 8'hFF, 8'h02, 8'h01, 8'h01, 2, 0, 8'h01};
    tbl[3] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h7F, 8'h01, 5, 1, 8'h80};
    tbl[4] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h80, 8'h80, 2, 1, 8'h00};
    tbl[5] = '{1'b1, 1'b1, 8'h33, 8'h44, 8'h55, 8'h66, 3, 0, 8'h77};
    tbl[6] = '{1'b1, 1'b0, 8'h0A, 8'h0B, 8'hEE, 8'hEE, 2, 0, 8'h15};
    tbl[7] = '{1'b1, 1'b1, 8'h01, 8'h02, 8'hC8, 8'h37, 6, 1, 8'hFF};

    // reset state
    doReset();
    chk("rst ctl", {ack1, ack0, done1, done0, dp_start, err}, 6'b0);
    chk("rst result0", result0, 8'h00);
    chk("rst result1", result1, 8'h00);
    chk("rst dp_ina", dp_ina, 8'h00);
    chk("rst dp_inb", dp_inb, 8'h00);

    // vector table: one transaction per record, starting in IDLE
    eRes[0] = 8'h00; eRes[1] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1;
      a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
      dpLen = tbl[i].len;
      w = tbl[i].expW;
      tick();
      chk($sformatf("t%0d ack0", i), ack0, w == 0);
      chk($sformatf("t%0d ack1", i), ack1, w == 1);
      chk($sformatf("t%0d dp_start", i), dp_start, 1);
      chk($sformatf("t%0d dp_ina", i), dp_ina, w ? tbl[i].a1 : tbl[i].a0);
      chk($sformatf("t%0d dp_inb", i), dp_inb, w ? tbl[i].b1 : tbl[i].b0);
      req0 = 1'b0; req1 = 1'b0;
      nd = 1'b0;
      for (int j = 0; j < tbl[i].len; j++) begin
        tick();
        nd |= done0 | done1 | ack0 | ack1;
      end
      chk($sformatf("t%0d quiet", i), nd, 0);
      tick();
      chk($sformatf("t%0d done0", i), done0, w == 0);
      chk($sformatf("t%0d done1", i), done1, w == 1);
      chk($sformatf("t%0d result", i), w ? result1 : result0, tbl[i].expRes);
      chk($sformatf("t%0d other result", i), w ? result0 : result1, eRes[1-w]);
      chk($sformatf("t%0d err", i), err, 0);
      eRes[w] = tbl[i].expRes;
      tick();
    end

    // both requesting continuously from reset
    doReset();
    dpLen = 3; req0 = 1'b1; req1 = 1'b1;
    a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
    both = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (i == 26) begin req0 = 1'b0; req1 = 1'b0; end
      tick();
      if (ack0) gq.push_back(0);
      if (ack1) gq.push_back(1);
      if (done0) dq.push_back(0);
      if (done1) dq.push_back(1);
      if ((ack0 && ack1) || (done0 && done1)) both = 1'b1;
    end
    chk("c2 dual pulse", both, 0);
    chk("c2 grant count", gq.size(), 5);
    chk("c2 acks vs dones", dq.size(), gq.size());
    if (gq.size() >= 4 && dq.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("c2 grant%0d", i), gq[i], i % 2);
        chk($sformatf("c2 done%0d", i), dq[i], i % 2);
      end
    end else begin
      chk("c2 enough grants", 0, 1);
    end

    // req1 raised while requester 0 runs
    doReset();
    dpLen = 5; a0 = 8'h21; b0 = 8'h02; req0 = 1'b1;
    tick();
    chk("c3 ack0", ack0, 1);
    req0 = 1'b0;
    tick(); tick();
    req1 = 1'b1; a1 = 8'h40; b1 = 8'h04;
    seen = 1'b0; early = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (ack1) early = 1'b1;
      if (done0) seen = 1'b1;
    end
    chk("c3 early ack1", early, 0);
    chk("c3 done0 seen", seen, 1);
    chk("c3 result0", result0, 8'h23);
    tick();
    chk("c3 idle ack1", ack1, 0);
    tick();
    chk("c3 ack1", ack1, 1);
    chk("c3 dp_ina", dp_ina, 8'h40);
    req1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done1) seen = 1'b1;
    end
    chk("c3 done1 seen", seen, 1);
    chk("c3 result1", result1, 8'h44);
    tick();

    // reset in the middle of RUN
    doReset();
    dpLen = 2; req1 = 1'b1; a1 = 8'h12; b1 = 8'h34;
    tick();
    chk("c4 ack1", ack1, 1);
    req1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (done1) seen = 1'b1;
    end
    chk("c4 result1", result1, 8'h46);
    tick();
    dpLen = 8; req0 = 1'b1; a0 = 8'h0F; b0 = 8'h0E;
    tick();
    chk("c4 ack0", ack0, 1);
    req0 = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("c4 ctl", {ack1, ack0, done1, done0, dp_start, err}, 6'b0);
    chk("c4 result0", result0, 8'h00);
    chk("c4 result1", result1, 8'h00);
    chk("c4 dp_ina", dp_ina, 8'h00);
    chk("c4 dp_inb", dp_inb, 8'h00);
    reset = 1'b0; dpLen = 3;
    req0 = 1'b1; req1 = 1'b1; a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
    tick();
    chk("c4 rr reset ack0", ack0, 1);
    chk("c4 rr reset ack1", ack1, 0);
    req0 = 1'b0; req1 = 1'b0;
    nd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      nd |= done0 | done1;
    end
    chk("c4 no stale done", nd, 0);
    tick();
    chk("c4 done0", done0, 1);
    chk("c4 new result0", result0, 8'h02);
    tick();

    // randomized run against the transaction-level model
    doReset();
    eAck = '0; eDone = '0; eStart = 1'b0; eInA = '0; eInB = '0;
    eRes[0] = '0; eRes[1] = '0;
    idleFrom = 0; doneAt = -1; lastW = 1; opW = 0; opRes = '0;
    for (int k = 0; k < 500; k++) begin
      chk($sformatf("r%0d ctl", k), {ack1, ack0, done1, done0, dp_start, err},
          {eAck[1], eAck[0], eDone[1], eDone[0], eStart, 1'b0});
      chk($sformatf("r%0d result0", k), result0, eRes[0]);
      chk($sformatf("r%0d result1", k), result1, eRes[1]);
      chk($sformatf("r%0d dp_ina", k), dp_ina, eInA);
      chk($sformatf("r%0d dp_inb", k), dp_inb, eInB);
      r0 = ($urandom_range(0, 99) < 45);
      r1 = ($urandom_range(0, 99) < 45);
      req0 = r0; req1 = r1;
      a0 = 8'($urandom); b0 = 8'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      eAck = '0; eDone = '0; eStart = 1'b0;
      if (k >= idleFrom && (r0 || r1)) begin
        w = (r0 && r1) ? 1 - lastW : (r1 ? 1 : 0);
        lastW = w; opW = w;
        eAck[w] = 1'b1; eStart = 1'b1;
        eInA = w ? a1 : a0;
        eInB = w ? b1 : b0;
        opRes = eInA + eInB;
        dpLen = $urandom_range(2, 6);
        doneAt = k + 2 + dpLen;
        idleFrom = doneAt + 1;
      end else if (k + 1 == doneAt) begin
        eDone[opW] = 1'b1;
        eRes[opW] = opRes;
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (10) tick();

    // datapath busy stuck high
    doReset();
    dpStuck = 1'b1; dpLen = 3; req0 = 1'b1; a0 = 8'h11; b0 = 8'h11;
    tick();
    chk("c5 ack0", ack0, 1);
    req0 = 1'b0;
`ifdef DP_ARB_TIMEOUT_EN
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      early |= done0 | err;
    end
    chk("c5 early done", early, 0);
    tick();
    chk("c5 done0", done0, 1);
    chk("c5 err", err, 1);
    chk("c5 result0", result0, 8'hFF);
    tick();
    chk("c5 err pulse", err, 0);
`else
    nd = 1'b0; early = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      nd |= done0;
      early |= err;
    end
    chk("c5 no done0", nd, 0);
    chk("c5 err low", early, 0);
`endif
    dpStuck = 1'b0;
    repeat (10) tick();
    doReset();

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMis);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
